// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a retire counter.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes (adds the illegal port); otherwise they retire as NOPs.
module instr_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_en,
   output logic        rf_we,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic [2:0]  state,
   output logic [31:0] retire_count
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic        illegal
`endif
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_retireCount;

   logic        w_isBranch;
   logic        w_isLoad;
   logic        w_isStore;
   logic        w_isWriteback;
   logic        w_isFence;

   logic        w_memReq;
   logic        w_memWe;
   logic        w_irEn;
   logic        w_rfWe;
   logic        w_pcEn;
   logic [1:0]  w_pcSel;

   assign w_isBranch    = (opcode == OP_BRANCH);
   assign w_isLoad      = (opcode == OP_LOAD);
   assign w_isStore     = (opcode == OP_STORE);
   assign w_isWriteback = (opcode == OP_ALU)  || (opcode == OP_ALUI) ||
                          (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                          (opcode == OP_JAL)  || (opcode == OP_JALR);
   assign w_isFence     = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);

   // Control outputs and next state are pure decode of the current state and inputs.
   always_comb begin
      w_nextState = r_state;
      w_memReq    = 1'b0;
      w_memWe     = 1'b0;
      w_irEn      = 1'b0;
      w_rfWe      = 1'b0;
      w_pcEn      = 1'b0;
      w_pcSel     = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_memReq = 1'b1;
            if (mem_ready) begin
               w_irEn      = 1'b1;
               w_nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            w_nextState = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (w_isBranch) begin
               w_pcEn      = 1'b1;
               w_pcSel     = br_taken ? 2'b01 : 2'b00;
               w_nextState = S_FETCH;
            end else if (w_isLoad || w_isStore) begin
               w_nextState = S_MEM;
            end else if (w_isWriteback) begin
               w_nextState = S_WRITEBACK;
            end else if (w_isFence) begin
               w_pcEn      = 1'b1;
               w_nextState = S_FETCH;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               w_nextState = S_TRAP;
`else
               w_pcEn      = 1'b1;
               w_nextState = S_FETCH;
`endif
            end
         end
         S_MEM: begin
            w_memReq = 1'b1;
            w_memWe  = w_isStore;
            if (mem_ready) begin
               if (w_isStore) begin
                  w_pcEn      = 1'b1;
                  w_nextState = S_FETCH;
               end else begin
                  w_nextState = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: begin
            w_rfWe      = 1'b1;
            w_pcEn      = 1'b1;
            if (opcode == OP_JAL) begin
               w_pcSel = 2'b01;
            end else if (opcode == OP_JALR) begin
               w_pcSel = 2'b10;
            end
            w_nextState = S_FETCH;
         end
         S_TRAP: begin
            // Only reset leaves TRAP; without the trap build this state is never entered.
`ifdef ILLEGAL_TRAP_EN
            w_nextState = S_TRAP;
`else
            w_nextState = S_FETCH;
`endif
         end
         default: begin
            w_nextState = S_FETCH;
         end
      endcase
   end

   // Reset wins over everything, so a reset edge never counts a retirement.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FETCH;
         r_retireCount <= 32'd0;
      end else begin
         r_state <= w_nextState;
         if (w_pcEn) begin
            r_retireCount <= r_retireCount + 32'd1;
         end
      end
   end

   assign mem_req      = w_memReq;
   assign mem_we       = w_memWe;
   assign ir_en        = w_irEn;
   assign rf_we        = w_rfWe;
   assign pc_en        = w_pcEn;
   assign pc_sel       = w_pcSel;
   assign state        = r_state;
   assign retire_count = r_retireCount;
`ifdef ILLEGAL_TRAP_EN
   assign illegal      = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random instruction streams
// compared cycle by cycle against a per-instruction expected trace.
module tb_instr_sequencer;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        br_taken;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_en;
   logic        rf_we;
   logic        pc_en;
   logic [1:0]  pc_sel;
   logic [2:0]  state;
   logic [31:0] retire_count;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   int          tests  = 0;
   int          failed = 0;
   logic [31:0] expCount = 32'd0;

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       ir;
      logic       rf;
      logic       pc;
      logic [1:0] sel;
      logic       ill;
      logic       rdy;
   } step_t;

   typedef enum {K_BRANCH, K_LOAD, K_STORE, K_WB, K_FENCE, K_ILLEGAL} kind_t;

   instr_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .br_taken     (br_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .ir_en        (ir_en),
      .rf_we        (rf_we),
      .pc_en        (pc_en),
      .pc_sel       (pc_sel),
      .state        (state),
      .retire_count (retire_count)
`ifdef ILLEGAL_TRAP_EN
      ,
      .illegal      (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic kind_t classify(input logic [6:0] op);
      case (op)
         7'b1100011: return K_BRANCH;
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b0110011, 7'b0010011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: return K_WB;
         7'b0001111, 7'b1110011: return K_FENCE;
         default: return K_ILLEGAL;
      endcase
   endfunction

   function automatic step_t mk(input logic [2:0] st, input logic req, input logic we,
                                input logic ir, input logic rf, input logic pc,
                                input logic [1:0] sel, input logic ill, input logic rdy);
      step_t s;
      s.st  = st;
      s.req = req;
      s.we  = we;
      s.ir  = ir;
      s.rf  = rf;
      s.pc  = pc;
      s.sel = sel;
      s.ill = ill;
      s.rdy = rdy;
      return s;
   endfunction

   function automatic logic rnd();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkStep(input string tag, input step_t s);
      checkOutput({tag, ".state"},  32'(state),   32'(s.st));
      checkOutput({tag, ".memReq"}, 32'(mem_req), 32'(s.req));
      checkOutput({tag, ".memWe"},  32'(mem_we),  32'(s.we));
      checkOutput({tag, ".irEn"},   32'(ir_en),   32'(s.ir));
      checkOutput({tag, ".rfWe"},   32'(rf_we),   32'(s.rf));
      checkOutput({tag, ".pcEn"},   32'(pc_en),   32'(s.pc));
      checkOutput({tag, ".pcSel"},  32'(pc_sel),  32'(s.sel));
      checkOutput({tag, ".retire"}, retire_count, expCount);
`ifdef ILLEGAL_TRAP_EN
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'(s.ill));
`endif
   endtask

   // Builds the expected per-cycle trace of one instruction from its class, then plays it.
   // cut >= 0 stops after that many cycles (used to interrupt an instruction with reset).
   task automatic applyStimulus(input logic [6:0] op, input logic br, input int fWait,
                                input int mWait, input int cut, input string name);
      step_t q[$];
      kind_t k;
      logic  st;
      logic [1:0] wbSel;
      int    n;
      k  = classify(op);
      st = (k == K_STORE);
      wbSel = (op == 7'b1101111) ? 2'b01 : (op == 7'b1100111) ? 2'b10 : 2'b00;
      for (int i = 0; i < fWait; i++) q.push_back(mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
      q.push_back(mk(3'd0, 1, 0, 1, 0, 0, 2'b00, 0, 1));
      q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, rnd()));
      case (k)
         K_BRANCH: q.push_back(mk(3'd2, 0, 0, 0, 0, 1, br ? 2'b01 : 2'b00, 0, rnd()));
         K_LOAD, K_STORE: begin
            q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, rnd()));
            for (int i = 0; i < mWait; i++) q.push_back(mk(3'd3, 1, st, 0, 0, 0, 2'b00, 0, 0));
            q.push_back(mk(3'd3, 1, st, 0, 0, st, 2'b00, 0, 1));
            if (!st) q.push_back(mk(3'd4, 0, 0, 0, 1, 1, 2'b00, 0, rnd()));
         end
         K_WB: begin
            q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, rnd()));
            q.push_back(mk(3'd4, 0, 0, 0, 1, 1, wbSel, 0, rnd()));
         end
         K_FENCE: q.push_back(mk(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, rnd()));
         default: begin
`ifdef ILLEGAL_TRAP_EN
            q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, rnd()));
            for (int i = 0; i < 10; i++) q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 1, rnd()));
`else
            q.push_back(mk(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, rnd()));
`endif
         end
      endcase
      n = (cut >= 0 && cut < q.size()) ? cut : q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         opcode    = op;
         br_taken  = br;
         mem_ready = q[i].rdy;
         #1;
         checkStep($sformatf("%s[%0d]", name, i), q[i]);
         if (q[i].pc) expCount = expCount + 32'd1;
      end
   endtask

   task automatic applyReset(input string name);
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      expCount  = 32'd0;
      checkStep(name, mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
   endtask

   logic [6:0] opTable [13];

   initial begin
      rst       = 1'b1;
      opcode    = 7'b0000000;
      br_taken  = 1'b0;
      mem_ready = 1'b0;
      opTable = '{7'b1100011, 7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111,
                  7'b1110011, 7'b1111111, 7'b0000000};
      repeat (2) @(posedge clk);
      applyReset("reset");

      // ADDI: 0,1,2,4 then back to FETCH with one retirement.
      applyStimulus(7'b0010011, 1'b0, 0, 0, -1, "addi");
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checkOutput("addi.endState", 32'(state), 32'd0);
      checkOutput("addi.retire1", retire_count, 32'd1);

      applyStimulus(7'b1100011, 1'b1, 0, 0, -1, "beqTaken");
      applyStimulus(7'b1100011, 1'b0, 1, 0, -1, "beqNot");
      applyStimulus(7'b0000011, 1'b0, 0, 3, -1, "lw");
      applyStimulus(7'b1100111, 1'b0, 0, 0, -1, "jalr");
      applyStimulus(7'b1101111, 1'b0, 2, 0, -1, "jal");
      applyStimulus(7'b0100011, 1'b0, 0, 2, -1, "sw");
      applyStimulus(7'b0001111, 1'b0, 0, 0, -1, "fence");

      // Reset in the middle of a MEM wait: no retirement on that edge.
      applyStimulus(7'b0000011, 1'b0, 0, 3, 5, "lwCut");
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      #1;
      checkOutput("midMem.state", 32'(state), 32'd3);
      checkOutput("midMem.pcEn", 32'(pc_en), 32'd0);
      checkOutput("midMem.retire", retire_count, expCount);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      expCount = 32'd0;
      checkOutput("midMemRst.state", 32'(state), 32'd0);
      checkOutput("midMemRst.retire", retire_count, 32'd0);

      applyStimulus(7'b1111111, 1'b0, 0, 0, -1, "illegalOp");
`ifdef ILLEGAL_TRAP_EN
      applyReset("trapReset");
`endif

      for (int n = 0; n < 60; n++) begin
         logic [6:0] op;
         op = opTable[$urandom_range(0, 12)];
`ifdef ILLEGAL_TRAP_EN
         if (classify(op) == K_ILLEGAL) op = 7'b0110011;
`endif
         applyStimulus(op, rnd(), $urandom_range(0, 2), $urandom_range(0, 3), -1,
                       $sformatf("rnd%0d", n));
      end

      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checkOutput("final.retire", retire_count, expCount);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
